truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequencer that exhaustively exercises one 3-input logic gate (a truth-table block with in1/in2/in3/out).
- Drives all 8 input combinations in order, waits a programmable settle time per vector, and samples the gate output.
- Assembles the captured 8-bit truth table and compares it against an expected table supplied at start.
- Sits between test/config logic and a single gate instance. Provides self-check of synthesized circuit hex IDs (e.g. 0xD9).

Parameters:
- SETTLE_CYCLES, 4: extra cycles each vector is held before its sample edge. Legal range 0..255; each vector occupies SETTLE_CYCLES+1 cycles.

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a sweep; accepted only in IDLE
- abort  input  1  cancel the sweep in progress
- expected  input  8  expected truth table; sampled on the start-accept edge
- in1  output  1  gate input MSB of vector index
- in2  output  1  gate input middle bit
- in3  output  1  gate input LSB
- obs  input  1  gate output under test
- busy  output  1  high while sweeping
- done  output  1  one-cycle pulse when a sweep completes
- pass  output  1  captured == expected; valid from done, held until next start
- captured  output  8  measured truth table
- mismatch  output  8  captured XOR expected

Behaviour:
- Reset (rst=1 at edge): state IDLE. busy, done, pass = 0. captured, mismatch, expected latch = 8'h00. {in1,in2,in3} = 3'b000. Settle counter and index = 0. Reset overrides start and abort in the same cycle.
- Table bit convention (hex ID order): bit 7 = vector 000, bit 0 = vector 111. Vector k ({in1,in2,in3}=k) maps to captured[7-k].
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On start=1, at edge E0: latch expected, index=0, drive 000, clear captured, set busy=1, counter=SETTLE_CYCLES, go to SETTLE (or SAMPLE if SETTLE_CYCLES=0).
  - start while not in IDLE is ignored.
- SETTLE: counter decrements each cycle. At 1, go to SAMPLE.
- SAMPLE: at this edge:
  - captured[7-index] <= obs.
  - If index<7: index+1, drive the new vector, reload counter, go to SETTLE/SAMPLE.
  - If index=7: go to DONE.
- Timing: the sample of vector k occurs at edge E0+(SETTLE_CYCLES+1)*(k+1).
- DONE (one cycle):
  - done=1; busy=0; pass=(captured==expected); mismatch updated; inputs return to 000; go to IDLE.
  - A start seen in DONE is ignored (IDLE accepts start the next cycle).
- abort=1 while busy: next edge go to IDLE, busy=0, inputs 000, no done pulse. pass, captured and mismatch keep their pre-start values (cleared captured stays cleared). abort in IDLE has no effect.
- Simultaneous start+abort in IDLE: start wins.
- Outputs are registered; no combinational path from obs to any output.
- No other latency.

Test Plan:
- Reset then start with expected=8'hD9, SETTLE_CYCLES=4, obs driven by an ideal 0xD9 gate -> done exactly 40 cycles after E0; captured=8'hD9; pass=1; mismatch=8'h00.
- Same run, but obs forced to 1 for vector 010 -> captured=8'hF9, pass=0, mismatch=8'h20.
- Check the vector sequence on {in1,in2,in3}: 000,001,…,111, each held 5 cycles; busy high for all 40 cycles. Re-run with SETTLE_CYCLES=0 -> 1 cycle per vector; done at E0+8.
- Assert abort during vector 3 -> busy low next cycle, inputs 000, no done. A following start runs a full, correct sweep.
- Pulse start repeatedly during a sweep -> ignored. Change the expected bus mid-sweep -> result still uses the latched value.
- Assert rst mid-sweep -> all outputs 0 next cycle and state IDLE. Assert rst together with start -> stays idle.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps a 3-input gate through all 8 vectors and checks the captured truth table.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       obs,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] captured,
  output logic [7:0] mismatch
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  localparam logic [7:0] LP_SET = 8'(SETTLE_CYCLES);
  localparam state_t LP_RUN = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
  state_t r_state, w_next;
  logic [7:0] r_cnt, r_exp, r_cap, r_mm, w_cap;
  logic [2:0] r_idx;
  logic r_busy, r_done, r_pass;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   w_next = start ? LP_RUN : IDLE;
      SETTLE: w_next = abort ? IDLE : (r_cnt == 8'd1 ? SAMPLE : SETTLE);
      SAMPLE: w_next = abort ? IDLE : (r_idx == 3'd7 ? DONE : LP_RUN);
      DONE:   w_next = IDLE;
    endcase
  end
  // Vector k lands in bit 7-k so the table reads as the usual hex circuit ID.
  always_comb begin
    w_cap = r_cap;
    w_cap[3'd7 - r_idx] = obs;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_exp   <= 8'd0;
      r_cap   <= 8'd0;
      r_mm    <= 8'd0;
      r_idx   <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_exp  <= expected;
          r_idx  <= 3'd0;
          r_cap  <= 8'd0;
          r_busy <= 1'b1;
          r_cnt  <= LP_SET;
        end
        SETTLE: if (abort) begin
          r_busy <= 1'b0;
          r_idx  <= 3'd0;
        end else r_cnt <= r_cnt - 8'd1;
        SAMPLE: if (abort) begin
          r_busy <= 1'b0;
          r_idx  <= 3'd0;
        end else begin
          r_cap <= w_cap;
          if (r_idx == 3'd7) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (w_cap == r_exp);
            r_mm   <= w_cap ^ r_exp;
            r_idx  <= 3'd0;
          end else begin
            r_idx <= r_idx + 3'd1;
            r_cnt <= LP_SET;
          end
        end
        default: ;
      endcase
    end
  end
  assign {in1, in2, in3} = r_idx;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign captured = r_cap;
  assign mismatch = r_mm;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed table-driven checks of the truth-table sweeper.
module tb_truth_table_sweeper;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] expected = 8'h00, gate = 8'h00;
  logic frc = 1'b0;
  logic in1_4, in2_4, in3_4, busy4, done4, pass4, obs4;
  logic in1_0, in2_0, in3_0, busy0, done0, pass0, obs0;
  logic [7:0] cap4, mm4, cap0, mm0;
  logic [2:0] vec4, vec0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign vec4 = {in1_4, in2_4, in3_4};
  assign vec0 = {in1_0, in2_0, in3_0};
  // Ideal gate with an optional stuck-at-1 on vector 010.
  assign obs4 = (frc && vec4 == 3'b010) ? 1'b1 : gate[3'd7 - vec4];
  assign obs0 = (frc && vec0 == 3'b010) ? 1'b1 : gate[3'd7 - vec0];

  truth_table_sweeper #(.SETTLE_CYCLES(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
    .in1(in1_4), .in2(in2_4), .in3(in3_4), .obs(obs4), .busy(busy4), .done(done4),
    .pass(pass4), .captured(cap4), .mismatch(mm4));

  truth_table_sweeper #(.SETTLE_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
    .in1(in1_0), .in2(in2_0), .in3(in3_0), .obs(obs0), .busy(busy0), .done(done0),
    .pass(pass0), .captured(cap0), .mismatch(mm0));

  typedef struct {
    logic [7:0] ex;
    logic [7:0] gt;
    logic       fr;
    logic [7:0] cap;
    logic       ps;
    logic [7:0] mm;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a SETTLE_CYCLES=4 sweep; returns cycles from accept edge to done (-1 on timeout).
  task automatic sweep(input bit disturb, output int lat, output bit seq_ok);
    lat = -1;
    seq_ok = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done4) begin
        lat = c;
        break;
      end
      if (!busy4 || vec4 != 3'(c / 5)) seq_ok = 1'b0;
      if (disturb && c == 10) begin
        start = 1'b1;
        expected = 8'h00;
      end
      if (disturb && c == 13) start = 1'b0;
      step();
    end
  endtask

  initial begin
    int lat;
    bit ok;
    tbl[0] = '{8'hD9, 8'hD9, 1'b0, 8'hD9, 1'b1, 8'h00};
    tbl[1] = '{8'hD9, 8'hD9, 1'b1, 8'hF9, 1'b0, 8'h20};
    tbl[2] = '{8'h00, 8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF};
    tbl[3] = '{8'h01, 8'h80, 1'b1, 8'hA0, 1'b0, 8'hA1};
    tbl[4] = '{8'h96, 8'h96, 1'b0, 8'h96, 1'b1, 8'h00};
    tbl[5] = '{8'h3C, 8'h5A, 1'b0, 8'h5A, 1'b0, 8'h66};
    repeat (3) step();
    chk("rst_busy", int'(busy4), 0);
    chk("rst_done", int'(done4), 0);
    chk("rst_pass", int'(pass4), 0);
    chk("rst_cap", int'(cap4), 0);
    chk("rst_mm", int'(mm4), 0);
    chk("rst_vec", int'(vec4), 0);
    rst = 1'b0;
    step();
    foreach (tbl[i]) begin
      expected = tbl[i].ex;
      gate = tbl[i].gt;
      frc = tbl[i].fr;
      sweep(1'b0, lat, ok);
      chk($sformatf("t%0d_lat", i), lat, 40);
      chk($sformatf("t%0d_seq", i), int'(ok), 1);
      chk($sformatf("t%0d_cap", i), int'(cap4), int'(tbl[i].cap));
      chk($sformatf("t%0d_pass", i), int'(pass4), int'(tbl[i].ps));
      chk($sformatf("t%0d_mm", i), int'(mm4), int'(tbl[i].mm));
      chk($sformatf("t%0d_busy", i), int'(busy4), 0);
      chk($sformatf("t%0d_vec", i), int'(vec4), 0);
      step();
      chk($sformatf("t%0d_pulse", i), int'(done4), 0);
    end
    expected = 8'hD9;
    gate = 8'hD9;
    frc = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (16) step();
    chk("ab_vec3", int'(vec4), 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", int'(busy4), 0);
    chk("ab_vec", int'(vec4), 0);
    chk("ab_done", int'(done4), 0);
    chk("ab_pass", int'(pass4), 0);
    chk("ab_mm", int'(mm4), 8'h66);
    ok = 1'b1;
    repeat (50) begin
      step();
      if (done4 || busy4) ok = 1'b0;
    end
    chk("ab_quiet", int'(ok), 1);
    sweep(1'b0, lat, ok);
    chk("re_lat", lat, 40);
    chk("re_cap", int'(cap4), 8'hD9);
    chk("re_pass", int'(pass4), 1);
    chk("re_mm", int'(mm4), 0);
    step();
    sweep(1'b1, lat, ok);
    chk("dist_lat", lat, 40);
    chk("dist_seq", int'(ok), 1);
    chk("dist_cap", int'(cap4), 8'hD9);
    chk("dist_pass", int'(pass4), 1);
    chk("dist_mm", int'(mm4), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("done_start1", int'(busy4), 0);
    step();
    chk("done_start2", int'(busy4), 0);
    expected = 8'hD9;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    chk("mid_busy_pre", int'(busy4), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_busy", int'(busy4), 0);
    chk("mid_done", int'(done4), 0);
    chk("mid_pass", int'(pass4), 0);
    chk("mid_cap", int'(cap4), 0);
    chk("mid_mm", int'(mm4), 0);
    chk("mid_vec", int'(vec4), 0);
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    chk("rs_busy1", int'(busy4), 0);
    step();
    chk("rs_busy2", int'(busy4), 0);
    lat = -1;
    ok = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done0) begin
        lat = c;
        break;
      end
      if (!busy0 || vec0 != 3'(c)) ok = 1'b0;
      step();
    end
    chk("s0_lat", lat, 8);
    chk("s0_seq", int'(ok), 1);
    chk("s0_cap", int'(cap0), 8'hD9);
    chk("s0_pass", int'(pass0), 1);
    chk("s0_mm", int'(mm0), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
